// File: rtl/event_filter_if.sv
// AXI4-Lite register port used by event_filter; m = bus master, s = register slave.
interface axi4_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport m (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport s (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/event_filter.sv
// Receive-side event qualifier: drops K/null/unmasked symbols, writes qualified
// events into event_fifo with a lost flag, and exposes mask/counters over AXI4-Lite.
module event_filter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic       aclk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_k,
    input  logic       fifo_full,
    output logic       ev_valid,
    output logic [8:0] ev_data,
    axi4_lite_if.s     axi
);
    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_MASK   = 32'h04;
    localparam logic [31:0] A_DROP   = 32'h08;
    localparam logic [31:0] A_RXCNT  = 32'h0C;
    localparam logic [31:0] A_STATUS = 32'h10;

    logic             s1_vld_q, s1_vld_d;
    logic [7:0]       s1_code_q;
    logic             s2_vld_q;
    logic [7:0]       s2_code_q;
    logic             ev_vld_q, ev_vld_d;
    logic [8:0]       ev_data_q, ev_data_d;
    logic             enable_q, enable_d;
    logic [255:0]     mask_q, mask_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] rxc_q, rxc_d;
    logic             lost_q, lost_d;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             awready_q, awready_d;
    logic             bvalid_q, bvalid_d;

    logic accept, drop_ev, write_ev, wr_fire, rd_fire;
    logic unused_wr;

    // Clear wins over saturation but still counts a coinciding increment.
    function automatic logic [CNT_W-1:0] cnt_next(logic [CNT_W-1:0] c, logic inc, logic clr);
        if (clr) return CNT_W'(inc);
        if (inc && (c != '1)) return c + CNT_W'(1);
        return c;
    endfunction

    always_comb begin
        accept   = s2_vld_q & mask_q[s2_code_q];
        drop_ev  = accept & fifo_full;
        write_ev = accept & ~fifo_full;
        wr_fire  = awready_q & axi.awvalid & axi.wvalid;
        rd_fire  = arready_q & axi.arvalid;

        s1_vld_d  = rx_valid & ~rx_k & (rx_data != 8'h00) & enable_q;
        ev_vld_d  = write_ev;
        ev_data_d = write_ev ? {lost_q, s2_code_q} : ev_data_q;
        lost_d    = drop_ev ? 1'b1 : (write_ev ? 1'b0 : lost_q);

        enable_d = enable_q;
        mask_d   = mask_q;
        if (wr_fire) begin
            case (axi.awaddr)
                A_CTRL:  enable_d = axi.wdata[0];
                A_MASK:  mask_d[axi.wdata[7:0]] = axi.wdata[8];
                default: ;
            endcase
        end
        drop_d = cnt_next(drop_q, drop_ev, wr_fire && (axi.awaddr == A_DROP));
        rxc_d  = cnt_next(rxc_q, accept, wr_fire && (axi.awaddr == A_RXCNT));

        awready_d = axi.awvalid & axi.wvalid & ~awready_q & ~bvalid_q;
        bvalid_d  = wr_fire | (bvalid_q & ~axi.bready);
        rvalid_d  = rd_fire | (rvalid_q & ~axi.rready);
        arready_d = ~rvalid_d;

        rdata_d = rdata_q;
        if (rd_fire) begin
            case (axi.araddr)
                A_CTRL:   rdata_d = {31'b0, enable_q};
                A_DROP:   rdata_d = 32'(drop_q);
                A_RXCNT:  rdata_d = 32'(rxc_q);
                A_STATUS: rdata_d = {31'b0, lost_q};
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_code_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_code_q <= '0;
            ev_vld_q  <= 1'b0;
            ev_data_q <= '0;
            enable_q  <= 1'b0;
            mask_q    <= '0;
            drop_q    <= '0;
            rxc_q     <= '0;
            lost_q    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_code_q <= rx_data;
            s2_vld_q  <= s1_vld_q;
            s2_code_q <= s1_code_q;
            ev_vld_q  <= ev_vld_d;
            ev_data_q <= ev_data_d;
            enable_q  <= enable_d;
            mask_q    <= mask_d;
            drop_q    <= drop_d;
            rxc_q     <= rxc_d;
            lost_q    <= lost_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    assign ev_valid    = ev_vld_q;
    assign ev_data     = ev_data_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = 2'b00;
    assign axi.awready = awready_q;
    assign axi.wready  = awready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = 2'b00;

    // Byte strobes and upper write data carry no register state.
    assign unused_wr = ^{axi.wstrb, axi.wdata[31:9]};
endmodule

// File: tb/tb_event_filter.sv
// Randomized scoreboard bench for event_filter with a cycle-timed reference model.
module tb_event_filter;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;

    logic       aclk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_k = 1'b0;
    logic       fifo_full = 1'b0;
    logic       ev_valid;
    logic [8:0] ev_data;

    axi4_lite_if axi();

    event_filter #(.CNT_W(CNT_W)) dut (
        .aclk      (aclk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_k      (rx_k),
        .fifo_full (fifo_full),
        .ev_valid  (ev_valid),
        .ev_data   (ev_data),
        .axi       (axi)
    );

    always #5 aclk = ~aclk;

    typedef struct { bit v; bit [7:0] d; bit k; bit f; } sym_t;
    typedef struct { int due; logic [31:0] val; } exp_t;
    typedef struct { bit ok; bit [7:0] code; } pipe_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ev_count = 0;
    logic [8:0] last_ev = '0;
    bit full_hold = 1'b0;
    sym_t  sym_q[$];
    exp_t  evq[$];
    exp_t  rdq[$];
    pipe_t pipe[$];

    bit [255:0]  m_mask = '0;
    bit          m_en = 1'b0;
    bit          m_lost = 1'b0;
    int unsigned m_drop = 0;
    int unsigned m_rx = 0;

    function automatic sym_t mk(bit v, logic [7:0] d, bit k, bit f);
        sym_t s;
        s.v = v; s.d = d; s.k = k; s.f = f;
        return s;
    endfunction

    function automatic int unsigned cnt_nxt(int unsigned c, bit inc, bit clr);
        if (clr) return inc ? 1 : 0;
        if (inc && c < CMAX) return c + 1;
        return c;
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        case (a)
            32'h00:  return {31'b0, m_en};
            32'h08:  return m_drop;
            32'h0C:  return m_rx;
            32'h10:  return {31'b0, m_lost};
            default: return '0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        total++;
        bad++;
        $display("FAIL %s: got no response want response", name);
    endtask

    // Symbol driver: one queue entry per cycle, changed well after the edge.
    initial begin
        sym_t s;
        forever begin
            @(posedge aclk);
            #2;
            if (sym_q.size() > 0) s = sym_q.pop_front();
            else s = mk(0, 8'h00, 0, 0);
            rx_valid  = s.v;
            rx_data   = s.d;
            rx_k      = s.k;
            fifo_full = s.f | full_hold;
        end
    end

    // Reference model: a symbol sampled at edge N is judged at edge N+2.
    initial begin
        pipe_t p;
        exp_t  e;
        bit wr, inc_rx, inc_drop;
        forever begin
            @(posedge aclk);
            cyc++;
            if (reset) begin
                pipe.delete();
                rdq.delete();
                m_mask = '0; m_en = 0; m_lost = 0; m_drop = 0; m_rx = 0;
            end else begin
                if (axi.arvalid && axi.arready) begin
                    e.due = cyc; e.val = model_read(axi.araddr);
                    rdq.push_back(e);
                end
                wr = axi.awvalid && axi.wvalid && axi.awready;
                inc_rx = 0; inc_drop = 0;
                if (pipe.size() == 2) begin
                    p = pipe.pop_front();
                    if (p.ok && m_mask[p.code]) begin
                        inc_rx = 1;
                        if (fifo_full) begin
                            inc_drop = 1;
                            m_lost = 1;
                        end else begin
                            e.due = cyc; e.val = 32'({m_lost, p.code});
                            evq.push_back(e);
                            m_lost = 0;
                        end
                    end
                end
                p.ok = rx_valid && !rx_k && (rx_data != 8'h00) && m_en;
                p.code = rx_data;
                pipe.push_back(p);
                m_rx   = cnt_nxt(m_rx, inc_rx, wr && axi.awaddr == 32'h0C);
                m_drop = cnt_nxt(m_drop, inc_drop, wr && axi.awaddr == 32'h08);
                if (wr && axi.awaddr == 32'h00) m_en = axi.wdata[0];
                if (wr && axi.awaddr == 32'h04) m_mask[axi.wdata[7:0]] = axi.wdata[8];
            end
        end
    end

    // Monitor: strobes and read data must appear on the exact predicted cycle.
    initial begin
        exp_t e;
        bit rv_prev = 0;
        forever begin
            @(negedge aclk);
            while (evq.size() > 0 && evq[0].due < cyc) begin
                e = evq.pop_front();
                total++; bad++;
                $display("FAIL ev_missing: got no strobe want ev_data=%h", e.val);
            end
            if (ev_valid) begin
                ev_count++;
                last_ev = ev_data;
                if (evq.size() > 0 && evq[0].due == cyc) begin
                    e = evq.pop_front();
                    chk("ev_data", 32'(ev_data), e.val);
                end else begin
                    total++; bad++;
                    $display("FAIL ev_unexpected: got ev_data=%h want no strobe", ev_data);
                end
            end else if (evq.size() > 0 && evq[0].due == cyc) begin
                e = evq.pop_front();
                total++; bad++;
                $display("FAIL ev_missing: got no strobe want ev_data=%h", e.val);
            end
            while (rdq.size() > 0 && rdq[0].due < cyc) begin
                e = rdq.pop_front();
                total++; bad++;
                $display("FAIL rd_missing: got no rvalid want rdata=%h", e.val);
            end
            if (axi.rvalid && !rv_prev) begin
                if (rdq.size() > 0 && rdq[0].due == cyc) begin
                    e = rdq.pop_front();
                    chk("rdata", axi.rdata, e.val);
                    chk("rresp", 32'(axi.rresp), 32'h0);
                end else begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: got rdata=%h want no rvalid", axi.rdata);
                end
            end
            rv_prev = axi.rvalid;
        end
    end

    task automatic axi_write(logic [31:0] a, logic [31:0] d);
        int n;
        axi.awaddr = a; axi.wdata = d; axi.wstrb = '1;
        axi.awvalid = 1; axi.wvalid = 1; axi.bready = 1;
        n = 0;
        while (!axi.awready && n < 32) begin @(negedge aclk); n++; end
        if (!axi.awready) timeout("awready");
        @(negedge aclk);
        axi.awvalid = 0; axi.wvalid = 0;
        n = 0;
        while (!axi.bvalid && n < 32) begin @(negedge aclk); n++; end
        if (!axi.bvalid) timeout("bvalid");
        else chk("bresp", 32'(axi.bresp), 32'h0);
        @(negedge aclk);
        axi.bready = 0;
    endtask

    task automatic axi_read(logic [31:0] a, output logic [31:0] d);
        int n;
        axi.araddr = a; axi.arvalid = 1; axi.rready = 1;
        n = 0;
        while (!axi.arready && n < 32) begin @(negedge aclk); n++; end
        if (!axi.arready) timeout("arready");
        @(negedge aclk);
        axi.arvalid = 0;
        n = 0;
        while (!axi.rvalid && n < 32) begin @(negedge aclk); n++; end
        if (!axi.rvalid) timeout("rvalid");
        d = axi.rdata;
        @(negedge aclk);
        axi.rready = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sym_q.size() > 0 && n < 90000) begin @(negedge aclk); n++; end
        if (sym_q.size() > 0) timeout("drain");
        repeat (6) @(negedge aclk);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r, w, d0;
        int n0;
        axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0;
        axi.bready = 0; axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;

        repeat (3) @(negedge aclk);
        chk("arready_in_reset", 32'(axi.arready), 32'h0);
        chk("ev_valid_in_reset", 32'(ev_valid), 32'h0);
        reset = 0;
        @(negedge aclk);
        chk("arready_after_reset", 32'(axi.arready), 32'h1);
        chk("ev_data_reset", 32'(ev_data), 32'h0);
        chk("rvalid_reset", 32'(axi.rvalid), 32'h0);
        chk("bvalid_reset", 32'(axi.bvalid), 32'h0);
        axi_read(32'h00, r); chk("ctrl_reset", r, 32'h0);
        axi_read(32'h08, r); chk("drop_reset", r, 32'h0);

        // Basic stream, plus null and K codes enabled in the mask.
        axi_write(32'h00, 32'h1);
        for (int c = 1; c <= 4; c++) axi_write(32'h04, 32'h100 | 32'(c));
        axi_write(32'h04, 32'h100);
        axi_write(32'h04, 32'h1BC);
        n0 = ev_count;
        for (int c = 1; c <= 4; c++) sym_q.push_back(mk(1, 8'(c), 0, 0));
        drain();
        chk("basic_strobes", 32'(ev_count - n0), 32'h4);
        chk("basic_last", 32'(last_ev), 32'h004);
        axi_read(32'h0C, r); chk("rxcnt_4", r, 32'h4);

        n0 = ev_count;
        sym_q.push_back(mk(1, 8'h00, 0, 0));
        sym_q.push_back(mk(1, 8'hBC, 1, 0));
        sym_q.push_back(mk(1, 8'h05, 0, 0));
        drain();
        chk("filtered_none", 32'(ev_count - n0), 32'h0);
        axi_read(32'h0C, r); chk("rxcnt_still_4", r, 32'h4);

        // Drops under fifo_full and the lost flag.
        axi_write(32'h04, 32'h10F);
        full_hold = 1;
        for (int i = 0; i < 3; i++) sym_q.push_back(mk(1, 8'h0F, 0, 0));
        drain();
        axi_read(32'h08, r); chk("drop_3", r, 32'h3);
        axi_read(32'h10, r); chk("status_lost", r, 32'h1);
        full_hold = 0;
        sym_q.push_back(mk(1, 8'h0F, 0, 0));
        drain();
        chk("lost_event", 32'(last_ev), 32'h10F);
        sym_q.push_back(mk(1, 8'h0F, 0, 0));
        drain();
        chk("clean_event", 32'(last_ev), 32'h00F);
        axi_read(32'h10, r); chk("status_clear", r, 32'h0);

        // Mask clear committing on the edge where 0x05 is judged: old value wins.
        axi_write(32'h04, 32'h105);
        axi_read(32'h08, d0);
        n0 = ev_count;
        sym_q.push_back(mk(1, 8'h05, 0, 0));
        @(negedge aclk);
        @(negedge aclk);
        axi_write(32'h04, 32'h005);
        drain();
        chk("coincide_pass", 32'(ev_count - n0), 32'h1);
        chk("coincide_data", 32'(last_ev), 32'h005);
        sym_q.push_back(mk(1, 8'h05, 0, 0));
        drain();
        chk("masked_after", 32'(ev_count - n0), 32'h1);
        axi_read(32'h08, r); chk("drop_unchanged", r, d0);

        // Random traffic with concurrent register activity.
        for (int i = 0; i < 24; i++) begin
            w = 32'h20 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) w = w | 32'h100;
            axi_write(32'h04, w);
        end
        for (int i = 0; i < 600; i++)
            sym_q.push_back(mk($urandom_range(0, 3) != 0,
                               ($urandom_range(0, 9) == 0) ? 8'h00 : 8'(8'h20 + $urandom_range(0, 15)),
                               $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0));
        for (int i = 0; i < 400 && sym_q.size() > 0; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: begin
                    w = 32'h20 + 32'($urandom_range(0, 15));
                    if ($urandom_range(0, 1) == 1) w = w | 32'h100;
                    axi_write(32'h04, w);
                end
                3: begin
                    w = 32'($urandom_range(0, 5)) << 2;
                    axi_read(w, r);
                end
                4: axi_write(($urandom_range(0, 1) == 1) ? 32'h08 : 32'h0C, 32'h0);
                5: axi_write(32'h00, ($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
                6: axi_write(32'h14, 32'hFFFF_FFFF);
                default: @(negedge aclk);
            endcase
        end
        drain();
        for (int i = 0; i <= 5; i++) axi_read(32'(i) << 2, r);

        // Saturation of the drop counter.
        axi_write(32'h00, 32'h1);
        axi_write(32'h04, 32'h101);
        axi_write(32'h08, 32'h0);
        full_hold = 1;
        for (int i = 0; i < 65600; i++) sym_q.push_back(mk(1, 8'h01, 0, 0));
        drain();
        axi_read(32'h08, r); chk("drop_sat", r, CMAX);
        axi_read(32'h0C, r); chk("rxcnt_sat", r, CMAX);
        axi_write(32'h08, 32'h0);
        axi_read(32'h08, r); chk("drop_cleared", r, 32'h0);
        full_hold = 0;

        // Reset mid-burst with a read response still held.
        for (int i = 0; i < 40; i++) sym_q.push_back(mk(1, 8'h01, 0, 0));
        repeat (8) @(negedge aclk);
        axi.araddr = 32'h0C; axi.arvalid = 1; axi.rready = 0;
        @(negedge aclk);
        axi.arvalid = 0;
        @(negedge aclk);
        chk("rvalid_held", 32'(axi.rvalid), 32'h1);
        chk("burst_strobing", 32'(ev_valid), 32'h1);
        reset = 1;
        @(negedge aclk);
        chk("ev_valid_at_reset", 32'(ev_valid), 32'h0);
        chk("rvalid_abandoned", 32'(axi.rvalid), 32'h0);
        sym_q.delete();
        repeat (2) begin
            @(negedge aclk);
            chk("ev_valid_in_reset2", 32'(ev_valid), 32'h0);
        end
        reset = 0;
        @(negedge aclk);
        chk("arready_after_reset2", 32'(axi.arready), 32'h1);
        axi_read(32'h00, r); chk("ctrl_after_reset", r, 32'h0);
        axi_write(32'h00, 32'h1);
        n0 = ev_count;
        sym_q.push_back(mk(1, 8'h01, 0, 0));
        drain();
        chk("mask_cleared", 32'(ev_count - n0), 32'h0);
        axi_read(32'h0C, r); chk("rxcnt_after_reset", r, 32'h0);
        axi_read(32'h04, r); chk("mask_reads_zero", r, 32'h0);
        chk("ev_queue_empty", 32'(evq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/event_filter.md
# event_filter

Receive-side event qualifier feeding event_fifo. Takes the recovered 8-bit symbol stream from the link receiver, discards K-characters, null codes and codes not enabled in a 256-entry mask, and issues qualified events on the 9-bit write port of event_fifo (`ev_valid`/`ev_data` drive `wr_en`/`data_in`). Keeps drop and receive statistics and exposes mask and counters over an AXI4-Lite slave on the same clock.

## Interface
Parameters
- `CNT_W`, 16: width of the drop and receive counters (saturating).

Ports
- `aclk`  in  1  system clock; all logic is on this single clock.
- `reset`  in  1  synchronous reset, active-high.
- `rx_valid`  in  1  receiver symbol strobe.
- `rx_data`  in  8  received symbol.
- `rx_k`  in  1  symbol is a K-character.
- `fifo_full`  in  1  event_fifo full flag.
- `ev_valid`  out  1  write strobe to event_fifo (`wr_en`).
- `ev_data`  out  9  [7:0] event code; [8] lost flag, i.e. events were dropped before this one.
- `axi`  slave  axi4_lite_if.s  register access.

## Operation
- Pipeline: S1 registers `rx_valid & ~rx_k & (rx_data != 8'h00) & enable` and the code. S2 looks up `mask[code]` and presents the event.
- Accepted at S2 when mask bit is 1. If `fifo_full`=1 in that cycle, the event is dropped: `drop_cnt`++, `lost_pending`←1. Otherwise `ev_valid`=1, `ev_data`={lost_pending, code}, and `lost_pending`←0. `rx_cnt`++ on every accepted event, written or dropped.
- Counters saturate at 2^CNT_W−1.
- Registers (byte address, 32-bit):
  - 0x00 CTRL: RW; bit0 enable (reset 0).
  - 0x04 MASK: WO; [7:0] code, bit8 value, writes `mask[code]`. Read returns 0.
  - 0x08 DROP: RO `drop_cnt`. Any write clears it.
  - 0x0C RXCNT: RO `rx_cnt`. Any write clears it.
  - 0x10 STATUS: RO; bit0 `lost_pending`.
  - Unmapped: reads return 0, writes are ignored. Responses are always OKAY (0).
- AXI read: `arready`=1 when no read is outstanding. Address accepted on `arvalid&arready`. `rvalid` asserted the next cycle with data and held until `rready`. `arready`=0 while `rvalid`=1.
- AXI write: `awready`/`wready` pulse together for one cycle only when `awvalid&wvalid` are both high. `bvalid` asserted the next cycle and held until `bready`. No new write is accepted while `bvalid`=1. `wstrb` is ignored.

## Timing
- Reset values: `ev_valid`=0, `ev_data`=0, all mask bits 0, enable 0, counters 0, `lost_pending` 0. AXI outputs: `arready`=0 during reset, then 1 from the first cycle after; `rvalid`, `awready`, `wready`, `bvalid` = 0; `rdata` = 0.
- Latency: a symbol sampled at edge N appears as `ev_valid` high in the cycle after edge N+2, i.e. it is registered at N+2. `ev_valid` is a one-cycle strobe per event. Back-to-back symbols give back-to-back strobes.
- `fifo_full` is sampled at the same edge that would register `ev_valid`.
- Mask write and lookup of the same code in the same cycle: the lookup uses the old value. The new value takes effect the following cycle.
- Counter clear coinciding with an increment: the counter becomes 1.
- `lost_pending` set and cleared in the same cycle cannot occur, because one event per cycle is either written or dropped.
- Clearing `enable` blocks S1 from the next edge. An event already in S2 still completes.
- Reset asserted mid-operation:
  - S1/S2 are flushed and no strobe is emitted on the reset edge or after.
  - The mask is cleared.
  - An in-flight AXI transaction is abandoned and `rvalid`/`bvalid` drop to 0.

## Test plan
- Reset → `ev_valid`=0. Read 0x00 returns 0. Read 0x08 returns 0. `rresp`=0.
- Enable=1, mask codes 0x01–0x04 set. Feed 0x01..0x04 on consecutive cycles with `rx_k`=0 → four strobes, `ev_data`=0x001..0x004, first strobe 3 edges after the first symbol. RXCNT reads 4.
- Feed 0x00, K-char 0xBC (`rx_k`=1), and unmasked 0x05 → no strobes, RXCNT unchanged.
- Hold `fifo_full`=1 and feed three 0x0F events → no strobes, DROP reads 3, STATUS reads 1. Release `fifo_full` and feed 0x0F → `ev_data`=0x10F. Next 0x0F gives `ev_data`=0x00F.
- Write 0x04 with 0x005 (clear mask for 5) in the same cycle a 0x05 reaches S2 → that event passes. The next 0x05 is dropped silently with no DROP increment.
- Drive 0x01 continuously with `fifo_full`=1 past 65535 events → DROP saturates at 0xFFFF. Write 0x08 → reads 0. Assert `reset` mid-burst → `ev_valid` low from the reset edge.
